// File: rtl/aes_cbc_pkg.sv
// Shared widths, FSM state type and stream beat payload for the AES CBC chaining controller.
package aes_cbc_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } cbc_state_t;

  typedef struct packed {
    logic                   last;
    logic [AES_BLOCK_W-1:0] data;
  } cbc_beat_t;

endpackage

// File: rtl/aes_cbc_if.sv
// Block stream interface: input blocks towards the CBC controller and result blocks back out.
interface aes_cbc_if;
  import aes_cbc_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller driving a single-block aes_core start/done interface.
// Optional done watchdog compiled in with AES_CBC_TIMEOUT_EN.
module aes_cbc_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_mode,
  input  logic [AES_KEY_W-1:0]   cfg_key,
  input  logic [AES_BLOCK_W-1:0] cfg_iv,
  input  logic                   cfg_load,
  aes_cbc_if.slave               bus,
  output logic                   core_start,
  output logic                   core_mode,
  output logic [AES_KEY_W-1:0]   core_key,
  output logic [AES_BLOCK_W-1:0] core_block_in,
  input  logic [AES_BLOCK_W-1:0] core_block_out,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   err_timeout
);

  cbc_state_t             state_q, state_d;
  cbc_beat_t              blk_q, blk_d;
  cbc_beat_t              res_q, res_d;
  logic [AES_BLOCK_W-1:0] chain_q, chain_d;
  logic [AES_BLOCK_W-1:0] iv_q, iv_d;
  logic [AES_BLOCK_W-1:0] core_in_q, core_in_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  logic                   mode_q, mode_d;
  logic                   start_q, start_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   in_ready_c;
  logic                   accept_c;

`ifdef AES_CBC_TIMEOUT_EN
  localparam int unsigned CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // A pending IV load takes priority over accepting a block.
  assign in_ready_c = (state_q == IDLE) && !cfg_load;
  assign accept_c   = in_ready_c && bus.in_valid;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    res_d       = res_q;
    chain_d     = chain_q;
    iv_d        = iv_q;
    core_in_d   = core_in_q;
    key_d       = key_q;
    mode_d      = mode_q;
    start_d     = 1'b0;
    out_valid_d = out_valid_q;
`ifdef AES_CBC_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          iv_d    = cfg_iv;
          chain_d = cfg_iv;
`ifdef AES_CBC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (accept_c) begin
          blk_d     = '{last: bus.in_last, data: bus.in_data};
          mode_d    = cfg_mode;
          key_d     = cfg_key;
          core_in_d = cfg_mode ? bus.in_data : (bus.in_data ^ chain_q);
          start_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef AES_CBC_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (core_done) begin
          res_d.data  = mode_q ? (core_block_out ^ chain_q) : core_block_out;
          res_d.last  = blk_q.last;
          chain_d     = mode_q ? blk_q.data : core_block_out;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
`ifdef AES_CBC_TIMEOUT_EN
        else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
          // Drop the block and restart chaining so the next message is clean.
          err_d   = 1'b1;
          chain_d = iv_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (blk_q.last) chain_d = iv_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      res_q       <= '0;
      chain_q     <= '0;
      iv_q        <= '0;
      core_in_q   <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      res_q       <= res_d;
      chain_q     <= chain_d;
      iv_q        <= iv_d;
      core_in_q   <= core_in_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AES_CBC_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(DONE_TIMEOUT);
  assign err_timeout    = 1'b0;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = res_q.data;
  assign bus.out_last   = res_q.last;
  assign core_start     = start_q;
  assign core_mode      = mode_q;
  assign core_key       = key_q;
  assign core_block_in  = core_in_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl with a table-driven stand-in for aes_core (known AES vectors).
module tb_aes_cbc_ctrl;
  import aes_cbc_pkg::*;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] X1  = 128'h6bc0bce12a459991e134741a7f9e1925; // P1 ^ IV2
  localparam logic [127:0] X2  = 128'hd86421fb9f1a1eda505ee1375746972c; // P2 ^ C1
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_mode, cfg_load;
  logic [127:0] cfg_key, cfg_iv;
  logic         core_start, core_mode, core_done, busy, err_timeout;
  logic [127:0] core_key, core_block_in, core_block_out;
  logic         mute, stale;
  int           chk = 0;
  int           pass = 0;

  aes_cbc_if bus();

  aes_cbc_ctrl #(.DONE_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_load(cfg_load),
    .bus(bus),
    .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
    .core_block_in(core_block_in), .core_block_out(core_block_out), .core_done(core_done),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, input logic [127:0] b);
    if (!m && k == K1 && b == PT0) return CT0;
    if (!m && k == K2 && b == X1)  return C1;
    if (!m && k == K2 && b == X2)  return C2;
    if (m && k == K2 && b == C1)   return X1;
    if (m && k == K2 && b == C2)   return X2;
    return b ^ k;
  endfunction

  // One-cycle core: done follows start by one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done      <= 1'b0;
      core_block_out <= '0;
    end else begin
      core_done      <= (core_start && !mute) || stale;
      core_block_out <= core_fn(core_mode, core_key, core_block_in);
    end
  end

  task automatic load_iv(input logic [127:0] iv);
    cfg_iv = iv; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic put_block(input logic [127:0] d, input logic l, input logic m, input logic [127:0] k);
    int n;
    n = 0;
    cfg_mode = m; cfg_key = k; bus.in_data = d; bus.in_last = l; bus.in_valid = 1'b1;
    #1;
    while (bus.in_ready !== 1'b1) begin
      if (n > 40) begin $display("FAIL accept_timeout waited=%0d", n); $fatal(1); end
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_out(output logic [127:0] d, output logic l, output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1) begin
      if (lat > 60) begin $display("FAIL out_valid_timeout waited=%0d", lat); $fatal(1); end
      @(negedge clk); lat++;
    end
    d = bus.out_data; l = bus.out_last;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); else pass++;
    chk++; if (bus.out_data !== '0) $display("FAIL rst_out_data got=%h want=0", bus.out_data); else pass++;
    chk++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last got=%b want=0", bus.out_last); else pass++;
    chk++; if ({core_start, core_mode, busy, err_timeout} !== 4'b0) $display("FAIL rst_ctrl got=%b want=0000", {core_start, core_mode, busy, err_timeout}); else pass++;
    chk++; if (core_key !== '0) $display("FAIL rst_core_key got=%h want=0", core_key); else pass++;
    chk++; if (core_block_in !== '0) $display("FAIL rst_core_block_in got=%h want=0", core_block_in); else pass++;
    chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); else pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enc_single;
    logic [127:0] d; logic l; int lat;
    load_iv('0);
    put_block(PT0, 1'b1, 1'b0, K1);
    chk++; if (core_start !== 1'b1) $display("FAIL enc1_start got=%b want=1", core_start); else pass++;
    chk++; if (core_block_in !== PT0) $display("FAIL enc1_block_in got=%h want=%h", core_block_in, PT0); else pass++;
    chk++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL enc1_busy got=%b/%b want=1/0", busy, bus.in_ready); else pass++;
    get_out(d, l, lat);
    chk++; if (lat !== 3) $display("FAIL enc1_latency got=%0d want=3", lat); else pass++;
    chk++; if (d !== CT0) $display("FAIL enc1_data got=%h want=%h", d, CT0); else pass++;
    chk++; if (l !== 1'b1) $display("FAIL enc1_last got=%b want=1", l); else pass++;
  endtask

  task automatic test_enc_chain;
    logic [127:0] d; logic l; int lat;
    load_iv(IV2);
    put_block(P1, 1'b0, 1'b0, K2);
    chk++; if (core_block_in !== X1) $display("FAIL encc_in1 got=%h want=%h", core_block_in, X1); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== C1 || l !== 1'b0) $display("FAIL encc_out1 got=%h/%b want=%h/0", d, l, C1); else pass++;
    put_block(P2, 1'b1, 1'b0, K2);
    chk++; if (core_block_in !== X2) $display("FAIL encc_in2 got=%h want=%h", core_block_in, X2); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== C2 || l !== 1'b1) $display("FAIL encc_out2 got=%h/%b want=%h/1", d, l, C2); else pass++;
  endtask

  task automatic test_dec_chain;
    logic [127:0] d; logic l; int lat;
    put_block(C1, 1'b0, 1'b1, K2);
    chk++; if (core_mode !== 1'b1 || core_block_in !== C1) $display("FAIL dec_in1 got=%b/%h want=1/%h", core_mode, core_block_in, C1); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== P1) $display("FAIL dec_out1 got=%h want=%h", d, P1); else pass++;
    put_block(C2, 1'b1, 1'b1, K2);
    get_out(d, l, lat);
    chk++; if (d !== P2 || l !== 1'b1) $display("FAIL dec_out2 got=%h/%b want=%h/1", d, l, P2); else pass++;
  endtask

  task automatic test_chain_from_iv;
    logic [127:0] d; logic l; int lat;
    put_block(P1, 1'b1, 1'b0, K2);
    get_out(d, l, lat);
    chk++; if (d !== C1) $display("FAIL msgA_out got=%h want=%h", d, C1); else pass++;
    put_block(P1, 1'b1, 1'b0, K2);
    chk++; if (core_block_in !== X1) $display("FAIL msgB_in got=%h want=%h", core_block_in, X1); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== C1) $display("FAIL msgB_out got=%h want=%h", d, C1); else pass++;
  endtask

  task automatic test_backpressure;
    logic [127:0] d0; int lat, starts, unstable, readies;
    bus.out_ready = 1'b0;
    put_block(P1, 1'b1, 1'b0, K2);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    d0 = bus.out_data;
    chk++; if (d0 !== C1) $display("FAIL bp_data got=%h want=%h", d0, C1); else pass++;
    bus.in_data = P2; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    starts = 0; unstable = 0; readies = 0;
    repeat (10) begin
      @(negedge clk);
      if (core_start) starts++;
      if (bus.in_ready) readies++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0) unstable++;
    end
    chk++; if (unstable !== 0) $display("FAIL bp_stable got=%0d want=0", unstable); else pass++;
    chk++; if (readies !== 0) $display("FAIL bp_in_ready got=%0d want=0", readies); else pass++;
    chk++; if (starts !== 0) $display("FAIL bp_start got=%0d want=0", starts); else pass++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release got=%b/%b want=0/0", bus.out_valid, busy); else pass++;
  endtask

  task automatic test_load_collision;
    logic [127:0] d; logic l; int lat;
    load_iv('0);
    cfg_iv = IV2; cfg_load = 1'b1; cfg_mode = 1'b0; cfg_key = K2;
    bus.in_data = P1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    #1;
    chk++; if (bus.in_ready !== 1'b0) $display("FAIL coll_in_ready got=%b want=0", bus.in_ready); else pass++;
    @(negedge clk);
    chk++; if (busy !== 1'b0 || core_start !== 1'b0) $display("FAIL coll_accepted got=%b/%b want=0/0", busy, core_start); else pass++;
    cfg_load = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk++; if (core_start !== 1'b1 || core_block_in !== X1) $display("FAIL coll_issue got=%b/%h want=1/%h", core_start, core_block_in, X1); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== C1) $display("FAIL coll_out got=%h want=%h", d, C1); else pass++;
  endtask

  task automatic test_stale_done;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    repeat (3) @(negedge clk);
    chk++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL stale_done got=%b/%b want=0/0", busy, bus.out_valid); else pass++;
  endtask

  task automatic test_timeout;
`ifdef AES_CBC_TIMEOUT_EN
    logic [127:0] d; logic l; int lat; logic seen;
    load_iv(IV2);
    mute = 1'b1;
    put_block(P1, 1'b0, 1'b0, K2);
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen = seen | bus.out_valid; end
    chk++; if (err_timeout !== 1'b0 || busy !== 1'b1) $display("FAIL to_early got=%b/%b want=0/1", err_timeout, busy); else pass++;
    @(negedge clk);
    seen = seen | bus.out_valid;
    chk++; if (err_timeout !== 1'b1 || busy !== 1'b0) $display("FAIL to_fire got=%b/%b want=1/0", err_timeout, busy); else pass++;
    chk++; if (seen !== 1'b0) $display("FAIL to_no_output got=%b want=0", seen); else pass++;
    mute = 1'b0;
    put_block(P1, 1'b1, 1'b0, K2);
    chk++; if (core_block_in !== X1 || err_timeout !== 1'b1) $display("FAIL to_rechain got=%h/%b want=%h/1", core_block_in, err_timeout, X1); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== C1) $display("FAIL to_after_out got=%h want=%h", d, C1); else pass++;
    load_iv(IV2);
    chk++; if (err_timeout !== 1'b0) $display("FAIL to_clear got=%b want=0", err_timeout); else pass++;
`else
    chk++; if (err_timeout !== 1'b0) $display("FAIL err_tied got=%b want=0", err_timeout); else pass++;
`endif
  endtask

  task automatic test_reset_mid;
    logic [127:0] d; logic l; int lat;
    load_iv(IV2);
    mute = 1'b1;
    put_block(PT0, 1'b1, 1'b0, K1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || core_start !== 1'b0)
      $display("FAIL midrst_state got=%b%b%b%b want=0100", busy, bus.in_ready, bus.out_valid, core_start); else pass++;
    @(negedge clk);
    rst_n = 1'b1; mute = 1'b0;
    @(negedge clk);
    put_block(PT0, 1'b1, 1'b0, K1);
    chk++; if (core_block_in !== PT0) $display("FAIL midrst_chain got=%h want=%h", core_block_in, PT0); else pass++;
    get_out(d, l, lat);
    chk++; if (d !== CT0) $display("FAIL midrst_out got=%h want=%h", d, CT0); else pass++;
  endtask

  initial begin
    cfg_mode = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    mute = 1'b0; stale = 1'b0;
    test_reset;
    test_enc_single;
    test_enc_chain;
    test_dec_chain;
    test_chain_from_iv;
    test_backpressure;
    test_load_collision;
    test_stale_done;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
